led_word_deserializer: RTL and testbench

- Bit-serial receiver that assembles MSB-first serial data into parallel words of WIDTH bits (default 30, the LED datapath word width).
- It is the receive end of the serial link that carries datapath words between LED boards.
- It presents completed words on a valid/ready output port through a single holding register.
- It flags framing errors and overruns.

---
 rtl/led_word_deserializer.sv | 154 +++++++++++++++
 tb/tb_led_word_deserializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_word_deserializer.sv
// -----------------------------------------------------------------------------
// led_word_deserializer
//
// Receive end of the bit-serial link that carries LED datapath words between
// boards. Serial bits arrive MSB first and are qualified by sin_valid. A bit
// with sin_start marks the first (most significant) bit of a word. Completed
// words go into a single holding register with a valid/ready output port.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   reset       in   synchronous, active-high reset
//   sin_valid   in   serial bit qualifier
//   sin_data    in   serial data bit, MSB of the word first
//   sin_start   in   marks the current qualified bit as bit WIDTH-1
//   word_data   out  assembled word (WIDTH bits), stable while word_valid=1
//   word_valid  out  holding register full
//   word_ready  in   consumer accepts when word_valid && word_ready
//   busy        out  a word is partially received
//   framing_err out  one-cycle pulse: a partial word was discarded by a restart
//   overrun     out  sticky: a completed word was dropped (cleared by reset)
// -----------------------------------------------------------------------------
module led_word_deserializer #(
  parameter  int WIDTH = 30,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_start,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             framing_err,
  output logic             overrun
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Count value before the final bit of a word is shifted in.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;
  logic             r_ferr;
  logic             r_overrun;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_word_nxt;
  logic             w_valid_nxt;
  logic             w_ferr_nxt;
  logic             w_overrun_nxt;
  logic             w_complete;
  logic [WIDTH-1:0] w_assembled;
  logic [WIDTH-1:0] w_first;

  // Bits enter at the LSB and move left, so the first bit received ends up
  // at bit WIDTH-1 once all WIDTH bits are in.
  assign w_assembled = {r_shift[WIDTH-2:0], sin_data};
  assign w_first     = {{(WIDTH-1){1'b0}}, sin_data};

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_ferr_nxt    = 1'b0;
    w_complete    = 1'b0;
    w_word_nxt    = r_word;
    w_valid_nxt   = r_word_valid;
    w_overrun_nxt = r_overrun;

    unique case (r_state)
      S_IDLE: begin
        // Qualified bits without a start marker are line noise between words.
        if (sin_valid && sin_start) begin
          w_shift_nxt = w_first;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sin_valid) begin
          if (sin_start) begin
            // Restart: drop the partial word and begin again with this bit,
            // even if it would have been the final bit.
            w_ferr_nxt  = 1'b1;
            w_shift_nxt = w_first;
            w_cnt_nxt   = CNT_W'(1);
          end else if (r_cnt == LAST_CNT) begin
            w_complete  = 1'b1;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_shift_nxt = w_assembled;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A completion can land in the holding register only if it is empty or
    // being drained on this same edge; otherwise the new word is dropped.
    if (w_complete) begin
      if (!r_word_valid || word_ready) begin
        w_word_nxt  = w_assembled;
        w_valid_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else if (r_word_valid && word_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_ferr       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_valid_nxt;
      r_ferr       <= w_ferr_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign word_data   = r_word;
  assign word_valid  = r_word_valid;
  assign busy        = (r_state == S_SHIFT);
  assign framing_err = r_ferr;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_led_word_deserializer.sv
// -----------------------------------------------------------------------------
// Testbench for led_word_deserializer (WIDTH = 30).
// A behavioural model tracks the expected outputs using integer bit counts and
// arithmetic accumulation; a negedge process compares every output each cycle.
// Directed sequences add literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_led_word_deserializer;

  localparam int W = 30;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sin_valid = 1'b0;
  logic         sin_data = 1'b0;
  logic         sin_start = 1'b0;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         busy;
  logic         framing_err;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  led_word_deserializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin_valid  (sin_valid),
    .sin_data   (sin_data),
    .sin_start  (sin_start),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] m_acc;
  int          m_cnt;
  bit          m_busy, m_valid, m_ferr, m_ovr;
  logic [63:0] m_data;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    bit done, ferr_n;
    done   = 1'b0;
    ferr_n = 1'b0;
    if (reset) begin
      m_acc = 0; m_cnt = 0; m_busy = 0; m_valid = 0;
      m_ferr = 0; m_ovr = 0; m_data = 0;
    end else begin
      if (sin_valid) begin
        if (sin_start) begin
          if (m_busy) ferr_n = 1'b1;
          m_acc  = 64'(sin_data);
          m_cnt  = 1;
          m_busy = 1'b1;
        end else if (m_busy) begin
          m_acc = m_acc * 2 + 64'(sin_data);
          m_cnt = m_cnt + 1;
          if (m_cnt == W) begin
            done   = 1'b1;
            m_busy = 1'b0;
            m_cnt  = 0;
          end
        end
      end
      if (done) begin
        if (!m_valid || word_ready) begin
          m_data  = m_acc;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && word_ready) begin
        m_valid = 1'b0;
      end
      m_ferr = ferr_n;
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model.word_valid", 64'(word_valid), 64'(m_valid));
      cmp("model.word_data", 64'(word_data), m_data & ((64'd1 << W) - 1));
      cmp("model.busy", 64'(busy), 64'(m_busy));
      cmp("model.framing_err", 64'(framing_err), 64'(m_ferr));
      cmp("model.overrun", 64'(overrun), 64'(m_ovr));
    end
  end

  // ---------------- stimulus helpers ----------------
  int busy_cnt, vld_cnt, ferr_cnt;

  task automatic clr_cnt();
    busy_cnt = 0; vld_cnt = 0; ferr_cnt = 0;
  endtask

  task automatic cyc(input logic v, input logic d, input logic s,
                     input logic r, input logic rs);
    sin_valid  = v;
    sin_data   = d;
    sin_start  = s;
    word_ready = r;
    reset      = rs;
    @(posedge clk);
    #1;
    busy_cnt += int'(busy);
    vld_cnt  += int'(word_valid);
    ferr_cnt += int'(framing_err);
  endtask

  // Sends the first nbits of w, MSB first, start marker on the first bit.
  task automatic send_word(input logic [W-1:0] w, input bit gap, input logic rdy,
                           input logic rdy_last, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      cyc(1'b1, w[W-1-k], (k == 0), (k == W-1) ? rdy_last : rdy, 1'b0);
      if (gap && k < nbits - 1) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    cmp("reset.word_valid", 64'(word_valid), 64'd0);
    cmp("reset.word_data", 64'(word_data), 64'd0);
    cmp("reset.busy", 64'(busy), 64'd0);
    cmp("reset.overrun", 64'(overrun), 64'd0);

    // Full-rate word
    clr_cnt();
    send_word(30'h15555555, 1'b0, 1'b1, 1'b1, W);
    cmp("full.valid_after_last", 64'(word_valid), 64'd1);
    cmp("full.data", 64'(word_data), 64'h15555555);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("full.busy_cycles", 64'(busy_cnt), 64'd29);
    cmp("full.valid_cycles", 64'(vld_cnt), 64'd1);
    cmp("full.framing_err", 64'(ferr_cnt), 64'd0);
    cmp("full.overrun", 64'(overrun), 64'd0);

    // Gapped word
    send_word(30'h3FFFFFFF, 1'b1, 1'b1, 1'b1, W);
    cmp("gap.valid_after_last", 64'(word_valid), 64'd1);
    cmp("gap.data", 64'(word_data), 64'h3FFFFFFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("gap.cleared", 64'(word_valid), 64'd0);

    // Restart mid-word
    clr_cnt();
    send_word(30'h2AAAAAAA, 1'b0, 1'b1, 1'b1, 12);
    send_word(30'h00000001, 1'b0, 1'b1, 1'b1, W);
    cmp("restart.valid", 64'(word_valid), 64'd1);
    cmp("restart.data", 64'(word_data), 64'h00000001);
    cmp("restart.ferr_pulses", 64'(ferr_cnt), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun with consumer stalled
    send_word(30'h0ABCDEF0, 1'b0, 1'b0, 1'b0, W);
    send_word(30'h12345678, 1'b0, 1'b0, 1'b0, W);
    cmp("ovr.valid", 64'(word_valid), 64'd1);
    cmp("ovr.data", 64'(word_data), 64'h0ABCDEF0);
    cmp("ovr.overrun", 64'(overrun), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("ovr.drained", 64'(word_valid), 64'd0);
    clr_cnt();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("ovr.no_second_word", 64'(vld_cnt), 64'd0);
    cmp("ovr.sticky", 64'(overrun), 64'd1);
    cmp("ovr.hold_data", 64'(word_data), 64'h0ABCDEF0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("ovr.reset_clears", 64'(overrun), 64'd0);

    // Accept and complete on the same edge
    send_word(30'h11111111, 1'b0, 1'b0, 1'b0, W);
    cmp("swap.first_held", 64'(word_data), 64'h11111111);
    send_word(30'h22222222, 1'b0, 1'b0, 1'b1, W);
    cmp("swap.valid", 64'(word_valid), 64'd1);
    cmp("swap.data", 64'(word_data), 64'h22222222);
    cmp("swap.overrun", 64'(overrun), 64'd0);

    // Reset while holding a word
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("rst_held.valid", 64'(word_valid), 64'd0);
    cmp("rst_held.data", 64'(word_data), 64'd0);

    // Reset mid-word
    send_word(30'h3C3C3C3C, 1'b0, 1'b1, 1'b1, 15);
    cmp("rst_mid.busy_before", 64'(busy), 64'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cmp("rst_mid.busy", 64'(busy), 64'd0);
    clr_cnt();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("rst_mid.nothing_out", 64'(vld_cnt), 64'd0);
    send_word(30'h02468ACE, 1'b0, 1'b1, 1'b1, W);
    cmp("rst_mid.next_valid", 64'(word_valid), 64'd1);
    cmp("rst_mid.next_data", 64'(word_data), 64'h02468ACE);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
